// File: rtl/branch_predictor_pkg.sv
// Shared constants for the branch target buffer: table size default and
// 2-bit saturating counter encodings.
package branch_predictor_pkg;

  localparam int unsigned ENTRY_BITS_DEFAULT = 6;

  typedef logic [1:0] cnt_t;

  localparam cnt_t CNT_SNT = 2'b00;
  localparam cnt_t CNT_WNT = 2'b01;
  localparam cnt_t CNT_WT  = 2'b10;
  localparam cnt_t CNT_ST  = 2'b11;

  localparam cnt_t CNT_ALLOC = CNT_WT;
  localparam cnt_t CNT_RESET = CNT_WNT;

endpackage

// File: rtl/branch_predictor_sat_counter2.sv
// Next-state of a 2-bit saturating history counter given the resolved outcome.
module branch_predictor_sat_counter2
  import branch_predictor_pkg::*;
(
  input  cnt_t cnt_i,
  input  logic taken_i,
  output cnt_t cnt_o
);

  always_comb begin
    cnt_o = cnt_i;
    if (taken_i) begin
      if (cnt_i != CNT_ST) cnt_o = cnt_i + 2'd1;
    end else begin
      if (cnt_i != CNT_SNT) cnt_o = cnt_i - 2'd1;
    end
  end

endmodule

// File: rtl/branch_predictor.sv
// Direct-mapped BTB with 2-bit counters: zero-latency fetch lookup, EX-stage
// training, misprediction flag and saturating resolve/miss statistics.
module branch_predictor
  import branch_predictor_pkg::*;
#(
  parameter int unsigned ENTRY_BITS = ENTRY_BITS_DEFAULT,
  parameter int unsigned TAG_BITS   = 30 - ENTRY_BITS
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] PC_IF,
  output logic        PredictF,
  output logic [31:0] PredictPC,
  input  logic        br_EX,
  input  logic [31:0] PC_EX_cur,
  input  logic        br,
  input  logic [31:0] br_target,
  input  logic        PredictE,
  output logic        mispredict,
  output logic [31:0] br_count,
  output logic [31:0] miss_count
);

  localparam int unsigned Entries = 1 << ENTRY_BITS;

  logic                valid_q  [Entries];
  logic [TAG_BITS-1:0] tag_q    [Entries];
  logic [31:0]         target_q [Entries];
  cnt_t                cnt_q    [Entries];

  logic [ENTRY_BITS-1:0] idx_if, idx_ex;
  logic [TAG_BITS-1:0]   tag_if, tag_ex;
  logic                  hit_if, hit_ex, wr_en;
  cnt_t                  cnt_sat, cnt_d;
  logic [31:0]           target_d;
  logic [31:0]           br_count_q, br_count_d, miss_count_q, miss_count_d;
  logic                  unused_pc_lsb;

  assign unused_pc_lsb = ^{PC_IF[1:0], PC_EX_cur[1:0]};

  assign idx_if = PC_IF[ENTRY_BITS+1:2];
  assign tag_if = PC_IF[31:ENTRY_BITS+2];
  assign idx_ex = PC_EX_cur[ENTRY_BITS+1:2];
  assign tag_ex = PC_EX_cur[31:ENTRY_BITS+2];

  assign hit_if    = valid_q[idx_if] && (tag_q[idx_if] == tag_if);
  assign PredictF  = hit_if & cnt_q[idx_if][1];
  assign PredictPC = PredictF ? target_q[idx_if] : 32'd0;

  assign mispredict = br_EX & (br != PredictE);

  assign hit_ex = valid_q[idx_ex] && (tag_q[idx_ex] == tag_ex);

  branch_predictor_sat_counter2 u_sat_counter2 (
    .cnt_i   (cnt_q[idx_ex]),
    .taken_i (br),
    .cnt_o   (cnt_sat)
  );

  // A not-taken miss leaves the table alone; everything else writes the entry.
  always_comb begin
    wr_en    = br_EX & (hit_ex | br);
    cnt_d    = hit_ex ? cnt_sat : CNT_ALLOC;
    target_d = br ? br_target : target_q[idx_ex];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < Entries; i++) begin
        valid_q[i]  <= 1'b0;
        tag_q[i]    <= '0;
        target_q[i] <= '0;
        cnt_q[i]    <= CNT_RESET;
      end
    end else if (wr_en) begin
      valid_q[idx_ex]  <= 1'b1;
      tag_q[idx_ex]    <= tag_ex;
      target_q[idx_ex] <= target_d;
      cnt_q[idx_ex]    <= cnt_d;
    end
  end

  always_comb begin
    br_count_d   = br_count_q;
    miss_count_d = miss_count_q;
    if (br_EX && (br_count_q != 32'hFFFF_FFFF)) br_count_d = br_count_q + 32'd1;
    if (mispredict && (miss_count_q != 32'hFFFF_FFFF)) miss_count_d = miss_count_q + 32'd1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      br_count_q   <= '0;
      miss_count_q <= '0;
    end else begin
      br_count_q   <= br_count_d;
      miss_count_q <= miss_count_d;
    end
  end

  assign br_count   = br_count_q;
  assign miss_count = miss_count_q;

endmodule

// File: tb/tb_branch_predictor.sv
// Self-checking bench: directed scenarios plus random traffic checked every
// cycle against a table-of-entries reference model.
module tb_branch_predictor;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] PC_IF, PC_EX_cur, br_target, PredictPC, br_count, miss_count;
  logic        PredictF, br_EX, br, PredictE, mispredict;

  int vectors = 0;
  int miscompares = 0;

  bit          m_valid [64];
  int unsigned m_tag   [64];
  logic [31:0] m_tgt   [64];
  int          m_cnt   [64];
  longint      m_brc, m_miss;

  branch_predictor dut (
    .clk        (clk),
    .rst        (rst),
    .PC_IF      (PC_IF),
    .PredictF   (PredictF),
    .PredictPC  (PredictPC),
    .br_EX      (br_EX),
    .PC_EX_cur  (PC_EX_cur),
    .br         (br),
    .br_target  (br_target),
    .PredictE   (PredictE),
    .mispredict (mispredict),
    .br_count   (br_count),
    .miss_count (miss_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 64; i++) begin
      m_valid[i] = 1'b0;
      m_tag[i]   = 0;
      m_tgt[i]   = 32'd0;
      m_cnt[i]   = 1;
    end
    m_brc  = 0;
    m_miss = 0;
  endtask

  task automatic model_update();
    int unsigned idx, tag;
    if (rst || !br_EX) return;
    if (m_brc < 64'hFFFF_FFFF) m_brc++;
    if ((br != PredictE) && (m_miss < 64'hFFFF_FFFF)) m_miss++;
    idx = (PC_EX_cur >> 2) % 64;
    tag = PC_EX_cur >> 8;
    if (m_valid[idx] && m_tag[idx] == tag) begin
      if (br) begin
        m_cnt[idx] = (m_cnt[idx] == 3) ? 3 : m_cnt[idx] + 1;
        m_tgt[idx] = br_target;
      end else begin
        m_cnt[idx] = (m_cnt[idx] == 0) ? 0 : m_cnt[idx] - 1;
      end
    end else if (br) begin
      m_valid[idx] = 1'b1;
      m_tag[idx]   = tag;
      m_tgt[idx]   = br_target;
      m_cnt[idx]   = 2;
    end
  endtask

  // Per-cycle comparison against the model, away from the rising edge.
  always @(negedge clk) begin
    int unsigned idx;
    logic        pf;
    logic [31:0] ppc;
    idx = (PC_IF >> 2) % 64;
    pf  = m_valid[idx] && (m_tag[idx] == (PC_IF >> 8)) && (m_cnt[idx] >= 2);
    ppc = pf ? m_tgt[idx] : 32'd0;
    chk("model_predictf", {31'd0, PredictF}, {31'd0, pf});
    chk("model_predictpc", PredictPC, ppc);
    chk("model_mispredict", {31'd0, mispredict}, {31'd0, br_EX && (br != PredictE)});
    chk("model_br_count", br_count, m_brc[31:0]);
    chk("model_miss_count", miss_count, m_miss[31:0]);
  end

  task automatic step();
    @(posedge clk);
    model_update();
    #1;
  endtask

  task automatic drive(input logic [31:0] pc_if, input logic bex, input logic [31:0] pc_ex,
                       input logic taken, input logic [31:0] tgt, input logic pe);
    PC_IF = pc_if; br_EX = bex; PC_EX_cur = pc_ex; br = taken; br_target = tgt; PredictE = pe;
  endtask

  initial begin
    rst = 1'b1;
    drive(32'd0, 1'b0, 32'd0, 1'b0, 32'd0, 1'b0);
    model_reset();
    step();
    step();
    rst = 1'b0;

    // Reset state lookup
    drive(32'h40, 1'b0, 32'd0, 1'b0, 32'd0, 1'b0);
    @(negedge clk);
    chk("reset_predictf", {31'd0, PredictF}, 32'd0);
    chk("reset_predictpc", PredictPC, 32'd0);
    chk("reset_br_count", br_count, 32'd0);
    chk("reset_miss_count", miss_count, 32'd0);
    step();

    // Allocate 0x40 -> 0x100 while fetching 0x40 in the same cycle
    drive(32'h40, 1'b1, 32'h40, 1'b1, 32'h100, 1'b0);
    @(negedge clk);
    chk("alloc_mispredict", {31'd0, mispredict}, 32'd1);
    chk("same_cycle_predictf", {31'd0, PredictF}, 32'd0);
    step();
    drive(32'h40, 1'b0, 32'd0, 1'b0, 32'd0, 1'b0);
    @(negedge clk);
    chk("alloc_predictf", {31'd0, PredictF}, 32'd1);
    chk("alloc_predictpc", PredictPC, 32'h100);
    chk("alloc_miss_count", miss_count, 32'd1);
    chk("alloc_br_count", br_count, 32'd1);
    step();

    for (int k = 0; k < 3; k++) begin
      drive(32'h40, 1'b1, 32'h40, 1'b1, 32'h100, 1'b1);
      @(negedge clk);
      chk("taken_predictf", {31'd0, PredictF}, 32'd1);
      chk("taken_no_mispredict", {31'd0, mispredict}, 32'd0);
      step();
    end

    // Strongly-taken needs two not-taken resolutions to flip
    drive(32'h40, 1'b1, 32'h40, 1'b0, 32'd0, 1'b1);
    step();
    drive(32'h40, 1'b0, 32'd0, 1'b0, 32'd0, 1'b0);
    @(negedge clk);
    chk("nt1_predictf", {31'd0, PredictF}, 32'd1);
    drive(32'h40, 1'b1, 32'h40, 1'b0, 32'd0, 1'b1);
    step();
    drive(32'h40, 1'b0, 32'd0, 1'b0, 32'd0, 1'b0);
    @(negedge clk);
    chk("nt2_predictf", {31'd0, PredictF}, 32'd0);
    chk("nt2_predictpc", PredictPC, 32'd0);
    chk("nt2_br_count", br_count, 32'd6);
    chk("nt2_miss_count", miss_count, 32'd3);
    step();

    // 0x140 shares index 16 with 0x40 but carries a different tag
    drive(32'h40, 1'b1, 32'h40, 1'b1, 32'h100, 1'b0);
    step();
    drive(32'h40, 1'b1, 32'h140, 1'b1, 32'h200, 1'b0);
    step();
    drive(32'h40, 1'b0, 32'd0, 1'b0, 32'd0, 1'b0);
    @(negedge clk);
    chk("alias_old_predictf", {31'd0, PredictF}, 32'd0);
    step();
    drive(32'h141, 1'b0, 32'd0, 1'b0, 32'd0, 1'b0);
    @(negedge clk);
    chk("alias_new_predictf", {31'd0, PredictF}, 32'd1);
    chk("alias_new_predictpc", PredictPC, 32'h200);
    step();

    // Random traffic over a small PC pool so hits, aliasing and saturation occur
    for (int n = 0; n < 1500; n++) begin
      drive(($urandom_range(0, 3) << 8) | ($urandom_range(0, 7) << 2) | $urandom_range(0, 3),
            1'($urandom_range(0, 2) != 0),
            ($urandom_range(0, 3) << 8) | ($urandom_range(0, 7) << 2) | $urandom_range(0, 3),
            1'($urandom_range(0, 1)), $urandom & 32'hFFFF_FFFC, 1'($urandom_range(0, 1)));
      step();
    end

    // Asynchronous reset in the middle of an update cycle
    drive(32'h40, 1'b1, 32'h40, 1'b1, 32'h300, 1'b0);
    step();
    drive(32'h40, 1'b1, 32'h40, 1'b1, 32'h300, 1'b0);
    #2;
    rst = 1'b1;
    model_reset();
    @(negedge clk);
    chk("midrst_predictf", {31'd0, PredictF}, 32'd0);
    chk("midrst_br_count", br_count, 32'd0);
    chk("midrst_miss_count", miss_count, 32'd0);
    chk("midrst_mispredict", {31'd0, mispredict}, 32'd1);
    step();
    step();
    rst = 1'b0;
    drive(32'h40, 1'b0, 32'd0, 1'b0, 32'd0, 1'b0);
    @(negedge clk);
    chk("post_rst_predictf", {31'd0, PredictF}, 32'd0);
    chk("post_rst_br_count", br_count, 32'd0);
    step();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/branch_predictor.md
Name: branch_predictor

Overview:
- Direct-mapped branch target buffer with 2-bit saturating-counter history.
- Supplies the fetch-stage prediction (PredictF, PredictPC) to the NPC generator.
- Trains on resolved conditional branches in EX, and reports misprediction plus running statistics.
- Sits between the IF-stage PC register and NPC_Generator; PredictF is carried down the pipeline by the IF/ID and ID/EX registers and returns as PredictE.

Parameters:
- ENTRY_BITS, 6, log2 of table entries (64). Index is PC[ENTRY_BITS+1:2].
- TAG_BITS, 30-ENTRY_BITS, tag width. Tag is PC[31:ENTRY_BITS+2]; full tag, so no aliasing.

Ports:
- clk  in  1  core clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- PC_IF  in  32  address of the instruction being fetched.
- PredictF  out  1  fetch-stage predict-taken.
- PredictPC  out  32  predicted target; zero when PredictF=0.
- br_EX  in  1  a conditional branch is resolving in EX this cycle (already gated by stall/flush upstream).
- PC_EX_cur  in  32  address of the branch in EX (not PC+4).
- br  in  1  actual branch outcome from the branch unit.
- br_target  in  32  actual branch target.
- PredictE  in  1  prediction carried with the EX branch.
- mispredict  out  1  br_EX & (br != PredictE), combinational.
- br_count  out  32  resolved branches since reset.
- miss_count  out  32  mispredictions since reset.

Behaviour:
- Storage per entry: valid (1), tag (TAG_BITS), target (32), cnt (2). Encoding: 00 strongly-NT, 01 weakly-NT, 10 weakly-T, 11 strongly-T.
- Lookup (combinational, zero latency):
  - hit = valid[idx_IF] & tag[idx_IF]==tag(PC_IF).
  - PredictF = hit & cnt[idx_IF][1].
  - PredictPC = PredictF ? target[idx_IF] : 0.
- Update happens only on a rising clk edge with br_EX=1; index and tag are taken from PC_EX_cur.
  - Hit, br=1: cnt = min(cnt+1, 11); target <= br_target.
  - Hit, br=0: cnt = max(cnt-1, 00); target unchanged.
  - Miss, br=1: allocate, overwriting any valid entry. Sets valid=1, tag, target=br_target, cnt=10.
  - Miss, br=0: no write.
- br_EX=0: table unchanged.
- Same index read and written in one cycle: lookup returns pre-update contents. The new contents are visible the following cycle.
- Counters:
  - br_count increments on every br_EX=1.
  - miss_count increments when mispredict=1.
  - Both saturate at 32'hFFFF_FFFF; no wrap.
- Reset (async, immediate on rst assertion, including mid-update):
  - All valid=0, all cnt=01, targets and tags=0.
  - br_count=0, miss_count=0.
  - Hence PredictF=0, PredictPC=0, and mispredict follows its inputs.
  - First update after deassertion is the first rising edge with rst=0.
- Low PC bits PC[1:0] are ignored. X on PC_IF must not corrupt state; lookup is read-only.
- The block never drives NPC. Recovery selection (br_target vs PC_EX+4) stays in NPC_Generator, using PredictE.

Decomposition:
- Shared package holds:
  - ENTRY_BITS default.
  - Counter encoding constants CNT_SNT, CNT_WNT, CNT_WT, CNT_ST.
  - CNT_ALLOC = CNT_WT and CNT_RESET = CNT_WNT.
- One natural sub-module: sat_counter2, the combinational next-state of a 2-bit saturating counter given taken. Instantiated once on the update path.

Test Plan:
- Reset, then PC_IF=0x0000_0040 → PredictF=0, PredictPC=0, br_count=0, miss_count=0.
- Branch at 0x40, target 0x100, taken, PredictE=0 → mispredict=1. Next cycle PC_IF=0x40 gives PredictF=1, PredictPC=0x100, cnt=10, miss_count=1.
- Same branch taken 3 more times → cnt=11 and stays 11. One not-taken resolution → cnt=10, PredictF still 1. Second not-taken → cnt=01, PredictF=0.
- Alias check: branch at 0x40 allocated; then taken branch at 0x140 (same index for ENTRY_BITS=6, tag differs) → entry replaced. Lookup at 0x40 misses (PredictF=0); lookup at 0x140 hits.
- Same-cycle read/write: PC_IF=0x40 while EX allocates 0x40 → PredictF=0 that cycle, 1 the next.
- Assert rst mid-run with br_EX=1 → table and counters clear immediately; after release, 0x40 lookup misses.
